// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the VGA timing generator and its consumers.
// The generator (master) receives the pixel clock-enable and drives the
// raster position, sync, strobe and test-pattern signals.
interface vga_timing_gen_if #(
    parameter int CW  = 11,
    parameter int FCW = 8
);
    logic           pix_ce;
    logic [CW-1:0]  hcount;
    logic [CW-1:0]  vcount;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           hsync;
    logic           vsync;
    logic           active;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;
    logic [11:0]    rgb;

    modport master (
        input  pix_ce,
        output hcount, vcount, x, y, hsync, vsync, active,
               line_start, frame_start, frame_count, rgb
    );

    modport slave (
        output pix_ce,
        input  hcount, vcount, x, y, hsync, vsync, active,
               line_start, frame_start, frame_count, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/raster timing generator advancing on a pixel clock-enable.
// Line and frame order: sync, back porch, active, front porch.
// Every output is registered and decoded from the next-state counter values,
// so sync/active/x/y/rgb are cycle-aligned with hcount/vcount.
// Optional macro VGA_TESTPAT_EN enables a built-in colour-bar source on rgb;
// without it rgb is tied to zero.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 11,
    parameter int FCW      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0       = H_SYNC + H_BP;
    localparam int VA0       = V_SYNC + V_BP;
    localparam int HA1       = HA0 + H_ACTIVE;
    localparam int VA1       = VA0 + V_ACTIVE;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA0_C  = CW'(HA0);
    localparam logic [CW-1:0] VA0_C  = CW'(VA0);
    localparam logic          HS_ON  = 1'(HS_POL);
    localparam logic          VS_ON  = 1'(VS_POL);

    // Counters must be able to hold every position of the raster.
    if ((64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0]  hcount_q, hcount_d;
    logic [CW-1:0]  vcount_q, vcount_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic [FCW-1:0] frame_count_q, frame_count_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           active_q, active_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic           h_wrap, v_wrap, h_act, v_act;

    // Next raster position and the outputs decoded from it; with pix_ce low
    // the counters hold, so the decoded levels hold and the strobes drop.
    always_comb begin
        h_wrap        = vif.pix_ce && (hcount_q == H_LAST);
        v_wrap        = h_wrap && (vcount_q == V_LAST);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;
        if (vif.pix_ce) begin
            hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            end
            if (v_wrap) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end
        hsync_d       = (32'(hcount_d) < 32'(H_SYNC)) ? HS_ON : ~HS_ON;
        vsync_d       = (32'(vcount_d) < 32'(V_SYNC)) ? VS_ON : ~VS_ON;
        h_act         = (32'(hcount_d) >= 32'(HA0)) && (32'(hcount_d) < 32'(HA1));
        v_act         = (32'(vcount_d) >= 32'(VA0)) && (32'(vcount_d) < 32'(VA1));
        active_d      = h_act && v_act;
        x_d           = active_d ? (hcount_d - HA0_C) : '0;
        y_d           = active_d ? (vcount_d - VA0_C) : '0;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    // State and output registers; reset puts the raster at (0,0) with both
    // syncs asserted, matching what position (0,0) decodes to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            hsync_q       <= HS_ON;
            vsync_q       <= VS_ON;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam int XW = (CW > 8) ? CW : 8;

    logic [XW-1:0] x_w;
    logic [2:0]    bar;
    logic [11:0]   rgb_q, rgb_d;

    // Colour bars from x[7:5]: 32-pixel wide stripes, black in blanking.
    always_comb begin
        x_w   = XW'(x_d);
        bar   = 3'(x_w >> 5);
        rgb_d = active_d ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
    end

    // Pattern register, aligned with x.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vif.rgb = rgb_q;
`else
    assign vif.rgb = 12'h000;
`endif

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.active      = active_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = frame_count_q;

endmodule
